video_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed-mode 720p/1080p generator.
- Produces hsync, vsync, data_en and pixel coordinates from one pixel clock, with a pixel-rate clock enable and a restart input for genlock.
- Feeds the DVI/TMDS encoders and any pixel source that needs x/y plus frame and line strobes.

---
 rtl/video_timing_pkg.sv | 46 ++++
 rtl/vtg_axis_counter.sv | 53 +++++
 rtl/video_timing_gen.sv | 155 +++++++++++++++
 tb/tb_video_timing_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types, standard CEA timing sets and sizing helpers
// for the video_timing_gen raster generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  // CEA-861 720p60, 1650 x 750 total
  localparam int P720_H_ACTIVE = 1280;
  localparam int P720_H_FP     = 110;
  localparam int P720_H_SYNC   = 40;
  localparam int P720_H_BP     = 220;
  localparam int P720_V_ACTIVE = 720;
  localparam int P720_V_FP     = 5;
  localparam int P720_V_SYNC   = 5;
  localparam int P720_V_BP     = 20;

  // CEA-861 1080p30, 2200 x 1125 total
  localparam int P1080_H_ACTIVE = 1920;
  localparam int P1080_H_FP     = 88;
  localparam int P1080_H_SYNC   = 44;
  localparam int P1080_H_BP     = 148;
  localparam int P1080_V_ACTIVE = 1080;
  localparam int P1080_V_FP     = 4;
  localparam int P1080_V_SYNC   = 5;
  localparam int P1080_V_BP     = 36;

  function automatic int vtg_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

  // Never returns zero so a one-entry axis still has a 1-bit bus
  function automatic int vtg_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter with wrap strobe and
// region decode (active, front porch, sync, back porch).
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 1,
  parameter int FP     = 1,
  parameter int SYNC   = 1,
  parameter int BP     = 1,
  localparam int TOTAL = vtg_total(ACTIVE, FP, SYNC, BP),
  localparam int CW    = vtg_w(TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output region_e       region,
  output logic          wrap
);

  localparam logic [CW-1:0] A_END = CW'(ACTIVE);
  localparam logic [CW-1:0] F_END = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] S_END = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    region = REG_BP;
    unique case (1'b1)
      (cnt < A_END):
        region = REG_ACTIVE;
      (cnt >= A_END) && (cnt < F_END):
        region = REG_FP;
      (cnt >= F_END) && (cnt < S_END):
        region = REG_SYNC;
      default:
        region = REG_BP;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with ce and genlock restart.
// Define VIDEO_TIMING_GEN_FRAME_CTR_EN to add the frame_cnt output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        restart,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        data_en,
  output logic [vtg_w(H_ACTIVE)-1:0]  x,
  output logic [vtg_w(V_ACTIVE)-1:0]  y,
  output logic                        line_start,
  output logic                        frame_start
`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
  ,
  output logic [15:0]                 frame_cnt
`endif
);

  localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = vtg_w(H_TOTAL);
  localparam int VW = vtg_w(V_TOTAL);
  localparam int XW = vtg_w(H_ACTIVE);
  localparam int YW = vtg_w(V_ACTIVE);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_bad_param
    $error("video_timing_gen: every timing parameter must be >= 1");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  region_e       h_reg;
  region_e       v_reg;
  logic          h_wrap;
  logic          v_wrap;
  logic          v_inc;

  assign v_inc = h_wrap & ce;

  vtg_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (ce),
    .clr    (restart),
    .cnt    (h_cnt),
    .region (h_reg),
    .wrap   (h_wrap)
  );

  vtg_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (v_inc),
    .clr    (restart),
    .cnt    (v_cnt),
    .region (v_reg),
    .wrap   (v_wrap)
  );

  // End-of-frame strobe is not needed downstream of the v axis
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  logic h_act;
  logic v_act;
  logic de_d;
  logic ls_d;
  logic fs_d;
  logic hs_d;
  logic vs_d;

  assign h_act = (h_reg == REG_ACTIVE);
  assign v_act = (v_reg == REG_ACTIVE);
  assign de_d  = h_act & v_act;
  assign ls_d  = (h_cnt == '0) & v_act;
  assign fs_d  = (h_cnt == '0) & (v_cnt == '0);
  assign hs_d  = (h_reg == REG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
  assign vs_d  = (v_reg == REG_SYNC) ? VSYNC_POL : ~VSYNC_POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      data_en     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (restart) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      data_en     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hsync       <= hs_d;
      vsync       <= vs_d;
      data_en     <= de_d;
      x           <= de_d ? XW'(h_cnt) : '0;
      y           <= de_d ? YW'(v_cnt) : '0;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
  // The first frame after reset/restart is frame 0
  logic fs_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      fs_seen   <= 1'b0;
    end else if (restart) begin
      frame_cnt <= '0;
      fs_seen   <= 1'b0;
    end else if (ce && fs_d) begin
      if (fs_seen) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      fs_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen in a 15x8 small mode,
// with an active-high and an active-low sync instance.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n_b = 1'b0;
  logic       ce = 1'b1;
  logic       restart = 1'b0;

  logic       hsync, vsync, data_en, line_start, frame_start;
  logic [2:0] x;
  logic [1:0] y;
  logic       hsync_n, vsync_n, de_n, ls_n, fs_n;
  logic [2:0] x_n;
  logic [1:0] y_n;
`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
  logic [15:0] frame_cnt, frame_cnt_n;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .restart(restart),
    .hsync(hsync), .vsync(vsync), .data_en(data_en),
    .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start)
`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n_b), .ce(ce), .restart(restart),
    .hsync(hsync_n), .vsync(vsync_n), .data_en(de_n),
    .x(x_n), .y(y_n), .line_start(ls_n),
    .frame_start(fs_n)
`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
    , .frame_cnt(frame_cnt_n)
`endif
  );

  // {data_en, x, y, hsync, vsync, line_start, frame_start}
  function automatic logic [9:0] obs();
    return {data_en, x, y, hsync, vsync, line_start, frame_start};
  endfunction

  // Output cycle k (1-based) of the first line after a frame origin
  function automatic logic [9:0] exp_first(input int k);
    logic       de, hs, st;
    logic [2:0] xx;
    de = (k >= 1) && (k <= 8);
    xx = de ? 3'(k - 1) : 3'd0;
    hs = (k >= 11) && (k <= 13);
    st = (k == 1);
    return {de, xx, 2'd0, hs, 1'b0, st, st};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_b = 1'b0; ce = 1'b1; restart = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", obs(), 10'b0);
    end
    n_cmp++;
    if ({hsync_n, vsync_n} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_pol_n: got %b want 11", {hsync_n, vsync_n});
    end
  endtask

  task automatic test_first_line();
    rst_n = 1'b1; rst_n_b = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      logic [9:0] e;
      step();
      e = exp_first(k);
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL first_line k=%0d: got %b want %b", k, obs(), e);
      end
      n_cmp++;
      if (hsync_n !== ~e[3]) begin
        n_err++;
        $display("FAIL first_line_hs_n k=%0d: got %b want %b",
                 k, hsync_n, ~e[3]);
      end
    end
  endtask

  task automatic test_full_frame();
    int waited = 0;
    int vs_cnt = 0, vs_first = -1, vs_last = -1;
    int ls_cnt = 0, hs_cnt = 0, fs_extra = 0, vsn_low = 0;
    while (!frame_start && waited < 200) begin
      step();
      waited++;
    end
    n_cmp++;
    if (!frame_start) begin
      n_err++;
      $display("FAIL frame_wait: got no frame_start want one in 200");
    end
    for (int i = 0; i < 120; i++) begin
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
        vs_last = i;
      end
      if (!vsync_n) vsn_low++;
      if (line_start) ls_cnt++;
      if (hsync) hs_cnt++;
      if (i > 0 && frame_start) fs_extra++;
      step();
    end
    n_cmp++;
    if (vs_cnt !== 30) begin
      n_err++;
      $display("FAIL vsync_width: got %0d want 30", vs_cnt);
    end
    n_cmp++;
    if (vs_first !== 75 || vs_last !== 104) begin
      n_err++;
      $display("FAIL vsync_pos: got %0d..%0d want 75..104",
               vs_first, vs_last);
    end
    n_cmp++;
    if (ls_cnt !== 4) begin
      n_err++;
      $display("FAIL line_starts: got %0d want 4", ls_cnt);
    end
    n_cmp++;
    if (hs_cnt !== 24) begin
      n_err++;
      $display("FAIL hsync_per_frame: got %0d want 24", hs_cnt);
    end
    n_cmp++;
    if (vsn_low !== 30) begin
      n_err++;
      $display("FAIL vsync_n_width: got %0d want 30", vsn_low);
    end
    n_cmp++;
    if (frame_start !== 1'b1 || fs_extra !== 0) begin
      n_err++;
      $display("FAIL frame_period: got fs=%b extra=%0d want 1/0",
               frame_start, fs_extra);
    end
  endtask

  task automatic test_ce_throttle();
    int cnt = 0, r1 = -1, r2 = -1, rises = 0;
    logic prev;
    restart = 1'b1; ce = 1'b0;
    step();
    restart = 1'b0;
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_err++;
      $display("FAIL restart_no_ce: got %b want %b", obs(), 10'b0);
    end
    prev = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ce = (n % 3 == 0);
      step();
      if (n % 3 == 0) cnt++;
      if (n < 45) begin
        n_cmp++;
        if (obs() !== exp_first(cnt)) begin
          n_err++;
          $display("FAIL ce_seq n=%0d: got %b want %b",
                   n, obs(), exp_first(cnt));
        end
      end
      if (frame_start && !prev) begin
        rises++;
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      prev = frame_start;
    end
    ce = 1'b1;
    n_cmp++;
    if (rises !== 2 || (r2 - r1) !== 360) begin
      n_err++;
      $display("FAIL ce_frame_period: got %0d rises gap %0d want 2/360",
               rises, r2 - r1);
    end
  endtask

  task automatic test_restart();
    ce = 1'b1; restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (36) step();
    n_cmp++;
    if (obs() !== {1'b1, 3'd5, 2'd2, 4'b0000}) begin
      n_err++;
      $display("FAIL pre_restart: got %b want %b",
               obs(), {1'b1, 3'd5, 2'd2, 4'b0000});
    end
    ce = 1'b0; restart = 1'b1;
    step();
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_err++;
      $display("FAIL restart_clear: got %b want %b", obs(), 10'b0);
    end
    restart = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_err++;
      $display("FAIL restart_hold: got %b want %b", obs(), 10'b0);
    end
    ce = 1'b1;
    step();
    n_cmp++;
    if (obs() !== exp_first(1)) begin
      n_err++;
      $display("FAIL restart_origin: got %b want %b",
               obs(), exp_first(1));
    end
  endtask

  task automatic test_polarity();
    int hs_low = 0, vs_low = 0;
    ce = 1'b1; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (k <= 15 && !hsync_n) hs_low++;
      if (!vsync_n) vs_low++;
    end
    n_cmp++;
    if (hs_low !== 3) begin
      n_err++;
      $display("FAIL hsync_n_width: got %0d want 3", hs_low);
    end
    n_cmp++;
    if (vs_low !== 5 || vsync_n !== 1'b0) begin
      n_err++;
      $display("FAIL vsync_n_active: got %0d low now %b want 5/0",
               vs_low, vsync_n);
    end
    #2;
    rst_n_b = 1'b0;
    #1;
    n_cmp++;
    if ({hsync_n, vsync_n, de_n, fs_n} !== 4'b1100) begin
      n_err++;
      $display("FAIL async_reset_n: got %b want 1100",
               {hsync_n, vsync_n, de_n, fs_n});
    end
    step();
    rst_n_b = 1'b1;
  endtask

`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
  task automatic test_frame_ctr();
    ce = 1'b1; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) step();
      else repeat (120) step();
      n_cmp++;
      if (frame_start !== 1'b1 || frame_cnt !== 16'(f)) begin
        n_err++;
        $display("FAIL frame_cnt f=%0d: got fs=%b cnt=%0d want 1/%0d",
                 f, frame_start, frame_cnt, f);
      end
    end
    repeat (119) step();
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    step();
    n_cmp++;
    if (frame_start !== 1'b1 || frame_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL frame_cnt_wrap: got fs=%b cnt=%h want 1/0000",
               frame_start, frame_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_line();
    test_full_frame();
    test_ce_throttle();
    test_restart();
    test_polarity();
`ifdef VIDEO_TIMING_GEN_FRAME_CTR_EN
    test_frame_ctr();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
